// File: rtl/glycemic_count_arbiter.sv
// Round-robin arbiter that time-shares one external 8-bit ones-counter among
// N_REQ sensor requesters and returns index, requester ID and threshold alarm.
//
// state   | meaning
// IDLE    | no work in flight; grants the next valid requester and latches its sample
// COMPUTE | operand register drives the shared counter; index and alarm captured at edge
// RESP    | response presented until rsp_ready; no new grant
module glycemic_count_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ALARM_TH = 6,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           pc_in,
  input  logic [3:0]           pc_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_index,
  output logic                 rsp_alarm,
  output logic [7:0]           alarm_count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } stateT;

  localparam logic [3:0]      ALARM_TH4 = 4'(ALARM_TH);
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(N_REQ - 1);

  stateT           state;
  stateT           stateNext;
  logic [7:0]      opReg;
  logic [ID_W-1:0] idReg;
  logic [ID_W-1:0] lastGrant;
  logic [3:0]      idxReg;
  logic            alarmReg;
  logic [7:0]      alarmCount;

  logic            grantFound;
  logic [ID_W-1:0] grantId;
  logic [7:0]      grantData;
  int              cand;
  logic [ID_W-1:0] candId;

  // Search starts just after the last grant so that requester has lowest priority.
  always_comb begin
    grantFound = 1'b0;
    grantId    = '0;
    cand       = 0;
    candId     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(lastGrant) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      candId = cand[ID_W-1:0];
      if (!grantFound && req_valid[candId]) begin
        grantFound = 1'b1;
        grantId    = candId;
      end
    end
  end

  always_comb begin
    grantData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantId == ID_W'(i)) begin
        grantData = req_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantFound) stateNext = COMPUTE;
      COMPUTE: stateNext = RESP;
      RESP:    if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grantFound) begin
      req_ready[grantId] = 1'b1;
    end
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opReg      <= '0;
      idReg      <= '0;
      lastGrant  <= LAST_INIT;
      idxReg     <= '0;
      alarmReg   <= 1'b0;
      alarmCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantFound) begin
            opReg     <= grantData;
            idReg     <= grantId;
            lastGrant <= grantId;
          end
        end
        COMPUTE: begin
          idxReg   <= pc_out;
          alarmReg <= (pc_out >= ALARM_TH4);
        end
        RESP: begin
          if (rsp_ready && alarmReg && alarmCount != 8'hFF) begin
            alarmCount <= alarmCount + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The shared counter sees the registered operand only, never live req_data.
  assign pc_in       = opReg;
  assign rsp_id      = idReg;
  assign rsp_index   = idxReg;
  assign rsp_alarm   = alarmReg;
  assign alarm_count = alarmCount;

endmodule

// File: tb/tb_glycemic_count_arbiter.sv
// Self-checking bench for glycemic_count_arbiter: models the shared ones-counter
// and checks grants/responses against a transaction-level reference model.
module tb_glycemic_count_arbiter;

  localparam int N_REQ    = 4;
  localparam int ALARM_TH = 6;
  localparam int ID_W     = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    reqValid;
  logic [8*N_REQ-1:0]  reqData;
  logic [N_REQ-1:0]    reqReady;
  logic [7:0]          pcIn;
  logic [3:0]          pcOut;
  logic                rspValid;
  logic                rspReady;
  logic [ID_W-1:0]     rspId;
  logic [3:0]          rspIndex;
  logic                rspAlarm;
  logic [7:0]          alarmCount;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  // reference model: one transaction in flight, aged in cycles since its grant
  int         mLast;
  bit         mInFlight;
  int         mAge;
  int         mId;
  int         mIdx;
  int         mAlarmCnt;
  int         mResponses;
  logic [7:0] mData;

  always #5 clk = ~clk;

  assign pcOut = 4'($countones(pcIn));

  glycemic_count_arbiter #(.N_REQ(N_REQ), .ALARM_TH(ALARM_TH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_data(reqData), .req_ready(reqReady),
    .pc_in(pcIn), .pc_out(pcOut),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId),
    .rsp_index(rspIndex), .rsp_alarm(rspAlarm),
    .alarm_count(alarmCount), .busy(busy)
  );

  function automatic void modelReset();
    mLast     = N_REQ - 1;
    mInFlight = 0;
    mAge      = 0;
    mAlarmCnt = 0;
  endfunction

  function automatic int pickGrant();
    for (int k = 1; k <= N_REQ; k++) begin
      int c;
      c = (mLast + k) % N_REQ;
      if (reqValid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] expReady();
    logic [N_REQ-1:0] r;
    int g;
    r = '0;
    g = pickGrant();
    if (!mInFlight && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic advance();
    int g;
    if (!mInFlight) begin
      g = pickGrant();
      if (g >= 0) begin
        mInFlight = 1;
        mAge      = 0;
        mId       = g;
        mData     = reqData[8*g +: 8];
        mIdx      = $countones(mData);
        mLast     = g;
      end
    end else if (mAge >= 2 && rspReady) begin
      if (mIdx >= ALARM_TH && mAlarmCnt < 255) mAlarmCnt++;
      mInFlight = 0;
      mResponses++;
    end
    if (mInFlight) mAge++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    reqValid = '0;
    rspReady = 1'b1;
    #1;
    while (mInFlight && n < 10) begin
      advance();
      n++;
    end
  endtask

  task automatic resetPulse();
    reqValid = '0;
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (reqReady !== '0 || busy !== 1'b0 || rspValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got ready=%b busy=%b rsp_valid=%b exp 0", reqReady, busy, rspValid);
    end
    checks++;
    if ({pcIn, rspId, rspIndex, rspAlarm, alarmCount} !== '0) begin
      failures++;
      $display("FAIL reset_data got pc_in=%h id=%0d idx=%0d alarm=%b cnt=%0d exp 0",
               pcIn, rspId, rspIndex, rspAlarm, alarmCount);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    reqValid = 4'b1001;
    reqData  = {8'hFF, 16'h0000, 8'h00};
    #1;
    checks++;
    if (reqReady !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b exp=0001", reqReady);
    end
    advance();
    reqValid = '0;
    #1;
    checks++;
    if (pcIn !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_compute got pc_in=%h busy=%b exp 00/1", pcIn, busy);
    end
    advance();
    checks++;
    if (rspValid !== 1'b1 || rspId !== 2'd0 || rspIndex !== 4'd0) begin
      failures++;
      $display("FAIL reset_rsp got v=%b id=%0d idx=%0d exp 1/0/0", rspValid, rspId, rspIndex);
    end
    rspReady = 1'b1;
    advance();
  endtask

  task automatic test_single();
    reqValid = 4'b0100;
    reqData  = '0;
    reqData[23:16] = 8'hB7;
    rspReady = 1'b1;
    #1;
    checks++;
    if (reqReady !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready got=%b exp=0100", reqReady);
    end
    advance();
    reqValid = '0;
    #1;
    checks++;
    if (rspValid !== 1'b0 || reqReady !== '0 || pcIn !== 8'hB7) begin
      failures++;
      $display("FAIL single_compute got v=%b ready=%b pc_in=%h exp 0/0/b7", rspValid, reqReady, pcIn);
    end
    advance();
    checks++;
    if (rspValid !== 1'b1 || rspId !== 2'd2 || rspIndex !== 4'd6 || rspAlarm !== 1'b1) begin
      failures++;
      $display("FAIL single_rsp got v=%b id=%0d idx=%0d alarm=%b exp 1/2/6/1",
               rspValid, rspId, rspIndex, rspAlarm);
    end
    advance();
    checks++;
    if (alarmCount !== 8'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_count got cnt=%0d busy=%b exp 1/0", alarmCount, busy);
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int gcyc[$];
    int expOrder[5] = '{0, 1, 2, 3, 0};
    resetPulse();
    reqValid = '1;
    rspReady = 1'b1;
    for (int c = 0; c < 13; c++) begin
      for (int i = 0; i < N_REQ; i++) reqData[8*i +: 8] = 8'($urandom);
      #1;
      checks++;
      if (reqReady !== expReady()) begin
        failures++;
        $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, reqReady, expReady());
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (reqReady[i]) begin
          grants.push_back(i);
          gcyc.push_back(c);
        end
      end
      if (mInFlight && mAge >= 2) begin
        checks++;
        if (rspValid !== 1'b1 || rspId !== ID_W'(mId) || rspIndex !== 4'(mIdx)) begin
          failures++;
          $display("FAIL rr_rsp cyc=%0d got v=%b id=%0d idx=%0d exp 1/%0d/%0d",
                   c, rspValid, rspId, rspIndex, mId, mIdx);
        end
      end
      advance();
    end
    drain();
    checks++;
    if (grants.size() != 5) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=5", grants.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (grants[k] != expOrder[k] || gcyc[k] != 3 * k) begin
          failures++;
          $display("FAIL rr_order k=%0d got id=%0d cyc=%0d exp id=%0d cyc=%0d",
                   k, grants[k], gcyc[k], expOrder[k], 3 * k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    reqValid = 4'b0010;
    reqData[15:8] = 8'h5A;
    rspReady = 1'b0;
    #1;
    checks++;
    if (reqReady !== 4'b0010) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=0010", reqReady);
    end
    advance();
    advance();
    for (int c = 0; c < 5; c++) begin
      reqData[15:8] = 8'($urandom);
      #1;
      checks++;
      if (rspValid !== 1'b1 || rspId !== 2'd1 || rspIndex !== 4'd4 || rspAlarm !== 1'b0
          || reqReady !== '0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b id=%0d idx=%0d alarm=%b ready=%b busy=%b exp 1/1/4/0/0/1",
                 c, rspValid, rspId, rspIndex, rspAlarm, reqReady, busy);
      end
      advance();
    end
    rspReady = 1'b1;
    #1;
    advance();
    checks++;
    if (reqReady !== 4'b0010 || rspValid !== 1'b0) begin
      failures++;
      $display("FAIL bp_regrant got ready=%b v=%b exp 0010/0", reqReady, rspValid);
    end
    advance();
    drain();
  endtask

  task automatic test_boundaries();
    logic [7:0] bdata  [3] = '{8'h00, 8'hFF, 8'h3E};
    int         bidx   [3] = '{0, 8, 5};
    logic       balarm [3] = '{1'b0, 1'b1, 1'b0};
    int r;
    for (int k = 0; k < 3; k++) begin
      r = $urandom_range(0, N_REQ - 1);
      reqValid = N_REQ'(1 << r);
      reqData[8*r +: 8] = bdata[k];
      rspReady = 1'b1;
      #1;
      advance();
      reqValid = '0;
      #1;
      checks++;
      if (pcIn !== bdata[k]) begin
        failures++;
        $display("FAIL bound_pc_in k=%0d got=%h exp=%h", k, pcIn, bdata[k]);
      end
      advance();
      checks++;
      if (rspValid !== 1'b1 || rspIndex !== 4'(bidx[k]) || rspAlarm !== balarm[k] || rspId !== ID_W'(r)) begin
        failures++;
        $display("FAIL bound_rsp k=%0d got v=%b idx=%0d alarm=%b id=%0d exp 1/%0d/%b/%0d",
                 k, rspValid, rspIndex, rspAlarm, rspId, bidx[k], balarm[k], r);
      end
      advance();
      checks++;
      if (alarmCount !== 8'(mAlarmCnt)) begin
        failures++;
        $display("FAIL bound_count k=%0d got=%0d exp=%0d", k, alarmCount, mAlarmCnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    reqValid = 4'b0010;
    reqData[15:8] = 8'hFF;
    rspReady = 1'b0;
    #1;
    advance();
    advance();
    checks++;
    if (rspValid !== 1'b1 || alarmCount === 8'd0) begin
      failures++;
      $display("FAIL midrst_pre got v=%b cnt=%0d exp v=1 cnt>0", rspValid, alarmCount);
    end
    reqValid = '0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({reqReady, pcIn, rspValid, rspId, rspIndex, rspAlarm, alarmCount, busy} !== '0) begin
      failures++;
      $display("FAIL midrst_zero got ready=%b pc_in=%h v=%b id=%0d idx=%0d alarm=%b cnt=%0d busy=%b exp all 0",
               reqReady, pcIn, rspValid, rspId, rspIndex, rspAlarm, alarmCount, busy);
    end
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    reqValid = 4'b1001;
    #1;
    checks++;
    if (reqReady !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_grant got=%b exp=0001", reqReady);
    end
    advance();
    drain();
  endtask

  task automatic test_random();
    bit expV;
    for (int c = 0; c < 400; c++) begin
      reqValid = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) reqData[8*i +: 8] = 8'($urandom);
      rspReady = ($urandom_range(0, 3) != 0);
      #1;
      expV = mInFlight && mAge >= 2;
      checks++;
      if (reqReady !== expReady()) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, reqReady, expReady());
      end
      checks++;
      if (rspValid !== expV || busy !== mInFlight) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got v=%b busy=%b exp %b/%b", c, rspValid, busy, expV, mInFlight);
      end
      checks++;
      if (alarmCount !== 8'(mAlarmCnt)) begin
        failures++;
        $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, alarmCount, mAlarmCnt);
      end
      if (mInFlight) begin
        checks++;
        if (pcIn !== mData) begin
          failures++;
          $display("FAIL rand_pc_in cyc=%0d got=%h exp=%h", c, pcIn, mData);
        end
      end
      if (expV) begin
        checks++;
        if (rspId !== ID_W'(mId) || rspIndex !== 4'(mIdx) || rspAlarm !== (mIdx >= ALARM_TH)) begin
          failures++;
          $display("FAIL rand_rsp cyc=%0d got id=%0d idx=%0d alarm=%b exp %0d/%0d/%b",
                   c, rspId, rspIndex, rspAlarm, mId, mIdx, (mIdx >= ALARM_TH));
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_saturation();
    int n;
    resetPulse();
    mResponses = 0;
    n = 0;
    reqValid = '1;
    reqData  = '1;
    rspReady = 1'b1;
    #1;
    while (mResponses < 300 && n < 1200) begin
      checks++;
      if (alarmCount !== 8'(mAlarmCnt)) begin
        failures++;
        $display("FAIL sat_track cyc=%0d got=%0d exp=%0d", n, alarmCount, mAlarmCnt);
      end
      advance();
      n++;
    end
    checks++;
    if (mResponses < 300) begin
      failures++;
      $display("FAIL sat_budget got=%0d responses exp=300", mResponses);
    end
    drain();
    checks++;
    if (alarmCount !== 8'd255) begin
      failures++;
      $display("FAIL sat_final got=%0d exp=255", alarmCount);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    reqValid = '0;
    reqData  = '0;
    rspReady = 1'b0;
    mResponses = 0;
    mData    = '0;
    mId      = 0;
    mIdx     = 0;
    modelReset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_boundaries();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glycemic_count_arbiter.md
# glycemic_count_arbiter

Round-robin arbiter and sequencer that shares the single combinational 8-bit ones-counter (8-bit sample in, 4-bit glycemic index out) among `N_REQ` sensor requesters. It accepts one 8-bit sample per grant, drives the shared counter from a registered operand, and captures the 4-bit index. It returns the index with requester ID and a threshold alarm over a valid/ready response channel. It sits between the sensor front-ends and the classification/display logic.

## Interface
- `N_REQ`, 4: number of requesters (2..8); `ID_W` = clog2(`N_REQ`), derived.
- `ALARM_TH`, 6: `rsp_alarm` asserted when index >= `ALARM_TH` (0..8).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester sample valid.
- `req_data`  in  8*N_REQ  sample of requester i on bits [8i+7:8i].
- `req_ready`  out  N_REQ  one-hot accept; combinational from state/`req_valid`/pointer.
- `pc_in`  out  8  operand to shared ones-counter (= operand register).
- `pc_out`  in  4  index returned by shared ones-counter (0..8).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  downstream accepts response.
- `rsp_id`  out  ID_W  requester that produced the response.
- `rsp_index`  out  4  captured glycemic index.
- `rsp_alarm`  out  1  `rsp_index` >= `ALARM_TH`.
- `alarm_count`  out  8  responses delivered with alarm; saturates at 255.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, COMPUTE, RESP.
- IDLE: if any `req_valid`, grant the first valid requester searching from `last_grant`+1 upward with wrap. Assert only its `req_ready` bit. Latch its data into `op_reg` and its ID into `id_reg`, set `last_grant`, then go to COMPUTE. With no valid requester, all `req_ready` stay 0 and the state holds.
- COMPUTE: `pc_in` = `op_reg`. At the clock edge, capture `pc_out` into `idx_reg`, compute alarm = (`pc_out` >= `ALARM_TH`), then go to RESP.
- RESP: `rsp_valid`=1 and `rsp_id`/`rsp_index`/`rsp_alarm` are stable from registers. On `rsp_valid`&`rsp_ready`, increment `alarm_count` if the alarm is set (saturating at 255), then go to IDLE. Otherwise hold, with no new grant.
- `req_ready` is 0 in COMPUTE and RESP. `req_valid` deasserting after a grant has no effect.
- Round-robin: the last granted requester has lowest priority next. After reset `last_grant` = `N_REQ`-1, so requester 0 has first priority.
- Arithmetic: the index is 0..8 in 4 bits. Compare unsigned. `ALARM_TH`=0 makes every response alarmed.
- Reset, at any state including mid-COMPUTE/RESP: state IDLE, `op_reg`=0 (so `pc_in`=0), `id_reg`=0, `idx_reg`=0, alarm=0, `last_grant`=`N_REQ`-1, `alarm_count`=0. The in-flight request is dropped with no response.

## Timing
- Reset values: `req_ready`=0 (until a valid request appears in IDLE), `pc_in`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_index`=0, `rsp_alarm`=0, `alarm_count`=0, `busy`=0.
- Handshake in cycle T (IDLE); COMPUTE in T+1; `rsp_valid` from T+2.
- With `rsp_ready` tied 1: response in T+2 only, next grant at T+3, throughput 1 per 3 cycles.
- `rsp_*` outputs are held unchanged while `rsp_valid`=1 and `rsp_ready`=0.
- `alarm_count` updates at the edge ending the response handshake.
- Shared counter path: `op_reg` -> counter -> `idx_reg` must close in one cycle.

## Test plan
- Reset: assert `rst` mid-RESP with `rsp_valid`=1 -> all outputs zero immediately (async). After release, req0 and req3 valid -> req0 granted first.
- Single request: req2 valid with data 8'hB7 -> `req_ready`=4'b0100 in T; at T+2 `rsp_valid`=1, `rsp_id`=2, `rsp_index`=6, `rsp_alarm`=1 (`ALARM_TH`=6), `alarm_count`=1 after handshake.
- Round-robin: all four valid continuously, `rsp_ready`=1 -> grant order 0,1,2,3,0 with grants 3 cycles apart.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP with req1 valid -> `rsp_*` stable, `req_ready`=0, `busy`=1. After `rsp_ready`=1, req1 is granted the next cycle.
- Boundaries: data 8'h00 -> index 0, no alarm. Data 8'hFF -> index 8, alarm. Data 8'h3E -> index 5, no alarm (one below threshold). 300 alarmed responses -> `alarm_count` stays 255.
